memstream_axilite_loader: RTL and testbench

//  AXI-lite write initiator that loads parameter memories such as the memstream AXI-lite config port.
//  - Accepts DEPTH entries of WIDTH bits on an AXI-stream input.
//  - Splits each entry into FOLD=ceil(WIDTH/32) 32-bit words and writes them at the folded word

---
 rtl/memstream_axilite_loader_if.sv | 48 ++++
 rtl/memstream_axilite_loader.sv | 144 ++++++++++++++
 tb/tb_memstream_axilite_loader.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memstream_axilite_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | memstream_axilite_loader_if                                                |
// | Entry stream input plus AXI-lite write channels of the parameter loader.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface memstream_axilite_loader_if #(
    parameter int WIDTH      = 73,
    parameter int ADDR_WIDTH = 14
);
    logic                  s_axis_tready;
    logic                  s_axis_tvalid;
    logic [WIDTH-1:0]      s_axis_tdata;
    logic                  m_awvalid;
    logic                  m_awready;
    logic [ADDR_WIDTH-1:0] m_awaddr;
    logic [2:0]            m_awprot;
    logic                  m_wvalid;
    logic                  m_wready;
    logic [31:0]           m_wdata;
    logic [3:0]            m_wstrb;
    logic                  m_bvalid;
    logic                  m_bready;
    logic [1:0]            m_bresp;

    modport master (
        output s_axis_tready,
        input  s_axis_tvalid, s_axis_tdata,
        output m_awvalid, m_awaddr, m_awprot,
        input  m_awready,
        output m_wvalid, m_wdata, m_wstrb,
        input  m_wready,
        input  m_bvalid, m_bresp,
        output m_bready
    );

    modport slave (
        input  s_axis_tready,
        output s_axis_tvalid, s_axis_tdata,
        input  m_awvalid, m_awaddr, m_awprot,
        output m_awready,
        input  m_wvalid, m_wdata, m_wstrb,
        output m_wready,
        output m_bvalid, m_bresp,
        input  m_bready
    );
endinterface
`default_nettype wire

// File: rtl/memstream_axilite_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | memstream_axilite_loader                                                   |
// | Streams DEPTH entries, splits each into 32-bit words, writes them over    |
// | AXI-lite at the folded word addresses of a memstream config port.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module memstream_axilite_loader #(
    parameter int DEPTH = 912,
    parameter int WIDTH = 73
) (
    input  wire                         ap_clk,
    input  wire                         ap_rst_n,
    input  wire                         restart,
    memstream_axilite_loader_if.master  bus,
    output logic                        done,
    output logic                        err
);
    localparam int FOLD               = 1 + (WIDTH - 1) / 32;
    localparam int FOLD_LOG           = $clog2(FOLD);
    localparam int AXILITE_ADDR_WIDTH = $clog2(DEPTH * (2 ** FOLD_LOG)) + 2;
    localparam int WORD_ADDR_W        = AXILITE_ADDR_WIDTH - 2;
    localparam int IDX_W              = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int J_W                = (FOLD > 1) ? FOLD_LOG : 1;
    localparam int ENTRY_W            = FOLD * 32;

    localparam logic [IDX_W-1:0] c_last_idx  = IDX_W'(DEPTH - 1);
    localparam logic [J_W-1:0]   c_last_word = J_W'(FOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_RESP  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [J_W-1:0]     r_word;
    logic [ENTRY_W-1:0] r_entry;
    logic               r_tready;
    logic               r_awvalid;
    logic               r_wvalid;
    logic               r_bready;
    logic               r_done;
    logic               r_err;

    logic [WORD_ADDR_W-1:0] w_word_addr;
    logic                   w_aw_fin;
    logic                   w_w_fin;

    // j never reaches 2**FOLD_LOG, so OR-ing it in equals adding it
    assign w_word_addr = (WORD_ADDR_W'(r_idx) << FOLD_LOG) | WORD_ADDR_W'(r_word);
    assign w_aw_fin    = !r_awvalid || bus.m_awready;
    assign w_w_fin     = !r_wvalid  || bus.m_wready;

    assign bus.s_axis_tready = r_tready;
    assign bus.m_awvalid     = r_awvalid;
    assign bus.m_awaddr      = {w_word_addr, 2'b00};
    assign bus.m_awprot      = 3'b000;
    assign bus.m_wvalid      = r_wvalid;
    assign bus.m_wdata       = r_entry[{r_word, 5'd0} +: 32];
    assign bus.m_wstrb       = 4'hF;
    assign bus.m_bready      = r_bready;
    assign done              = r_done;
    assign err               = r_err;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_word    <= '0;
            r_entry   <= '0;
            r_tready  <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (restart) begin
                        r_done <= 1'b0;
                        r_err  <= 1'b0;
                        r_idx  <= '0;
                        r_word <= '0;
                    end
                    // An entry offered together with restart is still taken, as entry 0
                    if (bus.s_axis_tvalid && r_tready) begin
                        r_entry   <= ENTRY_W'(bus.s_axis_tdata);
                        r_word    <= '0;
                        r_tready  <= 1'b0;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_state   <= S_WRITE;
                    end else begin
                        r_tready  <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (r_awvalid && bus.m_awready) r_awvalid <= 1'b0;
                    if (r_wvalid && bus.m_wready)   r_wvalid  <= 1'b0;
                    if (w_aw_fin && w_w_fin) begin
                        r_bready <= 1'b1;
                        r_state  <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.m_bvalid) begin
                        r_bready <= 1'b0;
                        if (bus.m_bresp != 2'b00) r_err <= 1'b1;
                        if (r_word != c_last_word) begin
                            r_word    <= r_word + 1'b1;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= S_WRITE;
                        end else if (r_idx != c_last_idx) begin
                            r_idx    <= r_idx + 1'b1;
                            r_word   <= '0;
                            r_tready <= 1'b1;
                            r_state  <= S_IDLE;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (restart) begin
                        r_done   <= 1'b0;
                        r_err    <= 1'b0;
                        r_idx    <= '0;
                        r_word   <= '0;
                        r_tready <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_memstream_axilite_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_memstream_axilite_loader                                                |
// | Directed bench: AXI-lite slave model with stalls/error injection.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_memstream_axilite_loader;
    localparam int DEPTH  = 912;
    localparam int WIDTH  = 73;
    localparam int ADDR_W = 14;
    localparam int WORDS  = 4096;
    localparam logic [31:0] c_fill = 32'hDEADBEEF;

    logic ap_clk   = 1'b0;
    logic ap_rst_n = 1'b0;
    logic restart  = 1'b0;
    logic done;
    logic err;

    memstream_axilite_loader_if #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_W)) bus ();

    memstream_axilite_loader #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .restart  (restart),
        .bus      (bus),
        .done     (done),
        .err      (err)
    );

    always #5 ap_clk = ~ap_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave model state
    logic [31:0]       mem [WORDS];
    int                nwrites    = 0;
    int                nerr_resp  = 0;
    int                proto_viol = 0;
    bit                err_inject = 1'b0;
    bit                capture_first = 1'b0;
    bit                saw_split  = 1'b0;
    logic [ADDR_W-1:0] first_addr = '0;

    function automatic int aw_stall_for(input logic [ADDR_W-1:0] a);
        int wa = int'(a >> 2);
        if (wa < 12) return 5;
        if (wa >= 24 && wa < 28) return 2;
        return 0;
    endfunction

    function automatic int w_stall_for(input logic [ADDR_W-1:0] a);
        int wa = int'(a >> 2);
        if (wa >= 12 && wa < 24) return 4;
        if (wa >= 24 && wa < 28) return 2;
        return 0;
    endfunction

    initial begin : slave
        bit aw_fire, w_fire, have_aw, have_w, b_fire, aw_seen, w_seen;
        int aw_stall, w_stall;
        logic [ADDR_W-1:0] aw_cap;
        logic [31:0]       w_cap;
        aw_fire = 0; w_fire = 0; have_aw = 0; have_w = 0; b_fire = 0; aw_seen = 0; w_seen = 0;
        aw_stall = 0; w_stall = 0; aw_cap = '0; w_cap = '0;
        bus.m_awready = 1'b0;
        bus.m_wready  = 1'b0;
        bus.m_bvalid  = 1'b0;
        bus.m_bresp   = 2'b00;
        forever begin
            @(negedge ap_clk);
            if (!ap_rst_n) begin
                aw_fire = 0; w_fire = 0; have_aw = 0; have_w = 0; b_fire = 0; aw_seen = 0; w_seen = 0;
                bus.m_awready = 1'b0;
                bus.m_wready  = 1'b0;
                bus.m_bvalid  = 1'b0;
                bus.m_bresp   = 2'b00;
                continue;
            end
            if (b_fire) begin
                mem[int'(aw_cap >> 2)] = w_cap;
                nwrites++;
                b_fire = 0; have_aw = 0; have_w = 0;
                bus.m_bvalid = 1'b0;
            end
            if (aw_fire) begin have_aw = 1; aw_fire = 0; aw_seen = 0; end
            if (w_fire)  begin have_w  = 1; w_fire  = 0; w_seen  = 0; end
            bus.m_awready = 1'b0;
            bus.m_wready  = 1'b0;
            if (bus.m_awvalid) begin
                if (have_aw) proto_viol++;
                else begin
                    if (!aw_seen) begin
                        aw_seen = 1; aw_cap = bus.m_awaddr; aw_stall = aw_stall_for(aw_cap);
                        if (capture_first) begin first_addr = aw_cap; capture_first = 0; end
                    end else if (bus.m_awaddr !== aw_cap) proto_viol++;
                    if (aw_stall > 0) aw_stall--;
                    else begin bus.m_awready = 1'b1; aw_fire = 1; end
                end
            end
            if (bus.m_wvalid) begin
                if (have_w) proto_viol++;
                else begin
                    if (!w_seen) begin
                        w_seen = 1; w_cap = bus.m_wdata; w_stall = w_stall_for(bus.m_awaddr);
                    end else if (bus.m_wdata !== w_cap) proto_viol++;
                    if (w_stall > 0) w_stall--;
                    else begin bus.m_wready = 1'b1; w_fire = 1; end
                end
            end
            if (have_w && bus.m_awvalid && !bus.m_wvalid) saw_split = 1;
            if (have_aw && have_w && !bus.m_bvalid) begin
                bus.m_bvalid = 1'b1;
                bus.m_bresp  = (err_inject && aw_cap == ADDR_W'(116)) ? 2'b10 : 2'b00;
                if (bus.m_bresp != 2'b00) nerr_resp++;
            end
            if (bus.m_bvalid && bus.m_bready) b_fire = 1;
            if (bus.s_axis_tready && (bus.m_awvalid || bus.m_wvalid || bus.m_bready)) proto_viol++;
        end
    end

    task automatic send_entry(input int i, output bit ok);
        logic [95:0] full;
        full = {32'(i * 4 + 2), 32'(i * 4 + 1), 32'(i * 4)};
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = full[WIDTH-1:0];
        ok = 0;
        for (int t = 0; t < 2000; t++) begin
            if (bus.s_axis_tready) begin ok = 1; break; end
            @(negedge ap_clk);
        end
        @(negedge ap_clk);
        bus.s_axis_tvalid = 1'b0;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge ap_clk);
        restart = 1'b0;
    endtask

    task automatic run_load(input bit probe, output bit ok_all);
        bit ok;
        ok_all = 1;
        for (int i = 0; i < DEPTH; i++) begin
            repeat ($urandom_range(0, 12)) @(negedge ap_clk);
            send_entry(i, ok);
            if (!ok) begin ok_all = 0; return; end
            if (probe && i == 10) begin
                for (int t = 0; t < 100 && !bus.m_bready; t++) @(negedge ap_clk);
                pulse_restart();
            end
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int t = 0; t < 500; t++) begin
            @(negedge ap_clk);
            if (done) begin ok = 1; break; end
        end
    endtask

    task automatic check_full(input string name);
        int mism = 0;
        logic [31:0] exp;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (j == 3)      exp = c_fill;
                else if (j == 2) exp = 32'(i * 4 + 2) & 32'h1FF;
                else             exp = 32'(i * 4 + j);
                if (mem[i * 4 + j] !== exp) mism++;
            end
        end
        check(name, 32'(mism), 32'd0);
    endtask

    typedef struct {
        int          word;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[12];

    task automatic check_table(input string tag);
        for (int k = 0; k < 12; k++)
            check($sformatf("%s_mem[%0d]", tag, vecs[k].word), mem[vecs[k].word], vecs[k].exp);
    endtask

    initial begin : main
        bit ok;
        int base;
        vecs[0]  = '{0, 32'd0};     vecs[1]  = '{1, 32'd1};
        vecs[2]  = '{2, 32'd2};     vecs[3]  = '{3, c_fill};
        vecs[4]  = '{4, 32'd4};     vecs[5]  = '{6, 32'd6};
        vecs[6]  = '{29, 32'd29};   vecs[7]  = '{30, 32'd30};
        vecs[8]  = '{510, 32'd510}; vecs[9]  = '{514, 32'd2};
        vecs[10] = '{3645, 32'd3645}; vecs[11] = '{3646, 32'd62};

        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = '0;
        for (int k = 0; k < WORDS; k++) mem[k] = c_fill;

        repeat (3) @(negedge ap_clk);
        check("rst_tready",  32'(bus.s_axis_tready), 32'd0);
        check("rst_awvalid", 32'(bus.m_awvalid), 32'd0);
        check("rst_wvalid",  32'(bus.m_wvalid), 32'd0);
        check("rst_bready",  32'(bus.m_bready), 32'd0);
        check("rst_done",    32'(done), 32'd0);
        check("rst_err",     32'(err), 32'd0);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        check("tready_after_reset", 32'(bus.s_axis_tready), 32'd1);
        check("awprot_wstrb", {25'd0, bus.m_awprot, bus.m_wstrb}, 32'h0000000F);

        // Load 1: stalls, error on word (7,1), restart probe while in RESP
        err_inject = 1; capture_first = 1;
        run_load(1'b1, ok);
        check("load1_stream", 32'(ok), 32'd1);
        wait_done(ok);
        check("load1_done", 32'(done), 32'd1);
        check("load1_err", 32'(err), 32'd1);
        check("load1_nwrites", 32'(nwrites), 32'd2736);
        check("load1_err_resps", 32'(nerr_resp), 32'd1);
        check("load1_first_addr", 32'(first_addr), 32'd0);
        check("aw_held_w_dropped", 32'(saw_split), 32'd1);
        check_table("load1");
        check_full("load1_mem_full");
        repeat (5) @(negedge ap_clk);
        check("done_quiet", {28'd0, bus.m_awvalid, bus.m_wvalid, bus.m_bready, bus.s_axis_tready}, 32'd0);
        check("err_sticky", 32'(err), 32'd1);

        // Restart from DONE, second full load without errors
        restart = 1'b1;
        @(negedge ap_clk);
        restart = 1'b0;
        check("restart_done_clr", 32'(done), 32'd0);
        check("restart_err_clr", 32'(err), 32'd0);
        check("restart_tready", 32'(bus.s_axis_tready), 32'd1);
        for (int k = 0; k < WORDS; k++) mem[k] = c_fill;
        nwrites = 0; nerr_resp = 0; err_inject = 0; capture_first = 1;
        run_load(1'b0, ok);
        check("load2_stream", 32'(ok), 32'd1);
        wait_done(ok);
        check("load2_done", 32'(done), 32'd1);
        check("load2_err", 32'(err), 32'd0);
        check("load2_nwrites", 32'(nwrites), 32'd2736);
        check("load2_first_addr", 32'(first_addr), 32'd0);
        check_table("load2");
        check_full("load2_mem_full");

        // Reset while entry 2 sits in WRITE with awready stalled
        pulse_restart();
        send_entry(0, ok);
        send_entry(1, ok);
        send_entry(2, ok);
        check("pre_reset_in_write", 32'(bus.m_awvalid), 32'd1);
        #2 ap_rst_n = 1'b0;
        #1;
        check("reset_drops_valids", {29'd0, bus.m_awvalid, bus.m_wvalid, bus.m_bready}, 32'd0);
        check("reset_tready_low", 32'(bus.s_axis_tready), 32'd0);
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        check("tready_after_midreset", 32'(bus.s_axis_tready), 32'd1);
        mem[0] = c_fill; mem[1] = c_fill; mem[2] = c_fill;
        base = nwrites; capture_first = 1;
        send_entry(9, ok);
        for (int t = 0; t < 200 && nwrites < base + 3; t++) @(negedge ap_clk);
        check("midreset_first_addr", 32'(first_addr), 32'd0);
        check("midreset_nwrites", 32'(nwrites - base), 32'd3);
        check("midreset_w0", mem[0], 32'd36);
        check("midreset_w2", mem[2], 32'd38);
        check("protocol_violations", 32'(proto_viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
